// File: rtl/ysyx_23060061_lsu.sv
// Load/store unit: turns one execute-stage memory operation at a time into a
// word-aligned valid/ready memory request and returns extended load data to writeback.
module ysyx_23060061_lsu #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_wen,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [4:0]  in_rd,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  output logic        mem_req_wen,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic [4:0]  out_rd,
  output logic        out_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t      state;
  logic [7:0]  cnt;
  logic        wen_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;

  logic        legal;
  logic        aligned;
  logic [3:0]  mask_c;
  logic [31:0] wdata_c;
  logic [31:0] shifted;
  logic [31:0] load_c;

  // in_ready is gated by rst so execute never sees a handshake during reset.
  assign in_ready = (state == IDLE) && !rst;

  // Decode of the incoming operation: legality, alignment and store lane encoding.
  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    legal   = 1'b0;
    aligned = 1'b0;
    mask_c  = 4'b0000;
    wdata_c = 32'h0;
    case (in_funct3)
      3'b000: begin
        legal   = 1'b1;
        aligned = 1'b1;
        mask_c  = 4'b0001 << in_addr[1:0];
      end
      3'b001: begin
        legal   = 1'b1;
        aligned = ~in_addr[0];
        mask_c  = 4'b0011 << in_addr[1:0];
      end
      3'b010: begin
        legal   = 1'b1;
        aligned = (in_addr[1:0] == 2'b00);
        mask_c  = 4'b1111;
      end
      3'b100: begin
        legal   = ~in_wen;
        aligned = 1'b1;
      end
      3'b101: begin
        legal   = ~in_wen;
        aligned = ~in_addr[0];
      end
      default: begin
        legal   = 1'b0;
        aligned = 1'b0;
      end
    endcase
    if (in_wen) begin
      wdata_c = in_wdata << {in_addr[1:0], 3'b000};
    end else begin
      mask_c = 4'b0000;
    end
  end

  // Load extraction from the returned word using the latched offset and width.
  always_comb begin
    shifted = mem_resp_rdata >> {off_q, 3'b000};
    load_c  = 32'h0;
    case (funct3_q)
      3'b000:  load_c = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_c = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_c = shifted;
      3'b100:  load_c = {24'h0, shifted[7:0]};
      3'b101:  load_c = {16'h0, shifted[15:0]};
      default: load_c = 32'h0;
    endcase
    if (wen_q) begin
      load_c = 32'h0;
    end
  end

  // NOTE: all state and registered outputs update with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= 8'h0;
      wen_q         <= 1'b0;
      funct3_q      <= 3'b000;
      off_q         <= 2'b00;
      mem_req_valid <= 1'b0;
      mem_req_addr  <= 32'h0;
      mem_req_wen   <= 1'b0;
      mem_req_wdata <= 32'h0;
      mem_req_wmask <= 4'b0000;
      out_valid     <= 1'b0;
      out_rdata     <= 32'h0;
      out_rd        <= 5'd0;
      out_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            wen_q    <= in_wen;
            funct3_q <= in_funct3;
            off_q    <= in_addr[1:0];
            out_rd   <= in_rd;
            if (legal && aligned) begin
              state         <= REQ;
              mem_req_valid <= 1'b1;
              mem_req_addr  <= {in_addr[31:2], 2'b00};
              mem_req_wen   <= in_wen;
              mem_req_wdata <= wdata_c;
              mem_req_wmask <= mask_c;
            end else begin
              // Illegal or misaligned: report straight back, no memory traffic.
              state     <= RESP;
              out_valid <= 1'b1;
              out_err   <= 1'b1;
              out_rdata <= 32'h0;
            end
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            state         <= WAIT;
            mem_req_valid <= 1'b0;
            cnt           <= 8'h0;
          end
        end
        WAIT: begin
          if (mem_resp_valid) begin
            state     <= RESP;
            out_valid <= 1'b1;
            out_err   <= 1'b0;
            out_rdata <= load_c;
          end else if (cnt + 8'd1 == TIMEOUT_C) begin
            state     <= RESP;
            out_valid <= 1'b1;
            out_err   <= 1'b1;
            out_rdata <= 32'h0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
